// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite/HUD ROM arbiter: requester indices,
// default bus widths and the return-tag record.
package sprite_pkg;

    localparam int REQ_P1  = 0;
    localparam int REQ_P2  = 1;
    localparam int REQ_HUD = 2;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 8;

    // Tag index width; supports up to four requesters.
    localparam int TAG_IDX_W = 2;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches req upward from ptr, wrapping,
// and returns a one-hot grant plus the winner's index.
module rr_arbiter #(
    parameter int NREQ  = 3,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] win_idx,
    output logic             any_gnt
);

    // cand_idx[k] = (ptr + k) mod NREQ; ptr < NREQ so one subtraction suffices.
    logic [IDX_W-1:0] cand_idx [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
        logic [IDX_W:0] sum;
        assign sum = {1'b0, ptr} + (IDX_W+1)'(gi);
        assign cand_idx[gi] = (sum >= (IDX_W+1)'(NREQ)) ?
                              IDX_W'(sum - (IDX_W+1)'(NREQ)) : sum[IDX_W-1:0];
    end

    always_comb begin
        gnt     = '0;
        win_idx = '0;
        any_gnt = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any_gnt && req[cand_idx[k]]) begin
                any_gnt = 1'b1;
                win_idx = cand_idx[k];
            end
        end
        if (any_gnt) begin
            gnt[win_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin sharing of the single-port sprite/HUD ROM between three fetchers.
// A tag pipeline tracks each issued read so its data returns to its owner.
module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ROM_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_sync,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*ADDR_W-1:0] addr,
    output logic [NREQ-1:0]        gnt,
    output logic                   rom_en,
    output logic [ADDR_W-1:0]      rom_addr,
    input  logic [DATA_W-1:0]      rom_data,
    output logic [NREQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   busy
);

    localparam int IDX_W = $clog2(NREQ);
    // Entry k of the tag pipeline is live k+1 cycles after the grant; the
    // last entry lines up with valid rom_data.
    localparam int DEPTH = ROM_LAT + 1;

    logic [IDX_W-1:0]  ptr_reg, ptr_next;
    logic [IDX_W-1:0]  win_idx;
    logic [NREQ-1:0]   arb_gnt;
    logic              any_gnt;
    logic [ADDR_W-1:0] addr_arr [NREQ];
    tag_t              tag_reg  [DEPTH];
    tag_t              tag_in;
    logic              rom_en_reg;
    logic [ADDR_W-1:0] rom_addr_reg;
    logic [NREQ-1:0]   rd_valid_reg, rd_valid_next;
    logic [DATA_W-1:0] rd_data_reg;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_addr
        assign addr_arr[gi] = addr[gi*ADDR_W +: ADDR_W];
    end

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req     (req),
        .ptr     (ptr_reg),
        .gnt     (arb_gnt),
        .win_idx (win_idx),
        .any_gnt (any_gnt)
    );

    assign gnt = rst_n ? arb_gnt : '0;

    // frame_sync wins over the grant-driven advance; arbitration still used ptr_reg.
    always_comb begin
        ptr_next = ptr_reg;
        if (frame_sync) begin
            ptr_next = '0;
        end else if (any_gnt) begin
            ptr_next = (win_idx == IDX_W'(NREQ-1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_comb begin
        tag_in       = '0;
        tag_in.valid = any_gnt;
        tag_in.idx   = TAG_IDX_W'(win_idx);
    end

    always_comb begin
        rd_valid_next = '0;
        if (tag_reg[DEPTH-1].valid) begin
            rd_valid_next[tag_reg[DEPTH-1].idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg      <= '0;
            rom_en_reg   <= 1'b0;
            rom_addr_reg <= '0;
            rd_valid_reg <= '0;
            rd_data_reg  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                tag_reg[k] <= '0;
            end
        end else begin
            ptr_reg    <= ptr_next;
            rom_en_reg <= any_gnt;
            if (any_gnt) begin
                rom_addr_reg <= addr_arr[win_idx];
            end
            tag_reg[0] <= tag_in;
            for (int k = 1; k < DEPTH; k++) begin
                tag_reg[k] <= tag_reg[k-1];
            end
            rd_valid_reg <= rd_valid_next;
            if (tag_reg[DEPTH-1].valid) begin
                rd_data_reg <= rom_data;
            end
        end
    end

    always_comb begin
        busy = |rd_valid_reg;
        for (int k = 0; k < DEPTH; k++) begin
            busy = busy | tag_reg[k].valid;
        end
    end

    assign rom_en   = rom_en_reg;
    assign rom_addr = rom_addr_reg;
    assign rd_valid = rd_valid_reg;
    assign rd_data  = rd_data_reg;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Randomised bench for sprite_rom_arbiter against a queue-based reference
// model of round-robin issue and fixed-latency return.
module tb_sprite_rom_arbiter;

    localparam int NREQ = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_sync = 1'b0;
    logic [2:0]  req = '0;
    logic [47:0] addr = '0;
    logic [2:0]  gnt;
    logic        rom_en;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data = '0;
    logic [2:0]  rd_valid;
    logic [7:0]  rd_data;
    logic        busy;

    always #5 clk = ~clk;

    sprite_rom_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_sync (frame_sync),
        .req        (req),
        .addr       (addr),
        .gnt        (gnt),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .busy       (busy)
    );

    function automatic logic [7:0] rom_fn(input logic [15:0] a);
        if (a == 16'h1234) return 8'hA5;
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // One-cycle ROM: data valid the cycle after rom_en.
    always @(posedge clk) if (rom_en) rom_data <= rom_fn(rom_addr);

    typedef struct { int due; int idx; logic [7:0] data; } ret_t;
    ret_t        q[$];
    int          cyc = 0, ptr_m = 0, n_tests = 0, n_fail = 0;
    logic        exp_en = 1'b0;
    logic [15:0] exp_addr = '0;
    logic [7:0]  last_data = '0;
    logic [15:0] a_arr [3] = '{default: '0};
    int          gnt_cnt [3] = '{default: 0};
    int          rv_cnt  [3] = '{default: 0};
    logic [2:0]  last_rv;
    logic [7:0]  last_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: check registered outputs, apply inputs, check grant, advance model.
    task automatic step(input logic [2:0] r, input logic fs, input logic rl, output logic [2:0] g);
        int         win;
        logic [2:0] exp_v;
        logic [7:0] exp_d;
        ret_t       e;
        @(posedge clk);
        cyc++;
        #1;
        check("rom_en", 32'(rom_en), 32'(exp_en));
        check("rom_addr", 32'(rom_addr), 32'(exp_addr));
        check("busy", 32'(busy), 32'(q.size() > 0));
        exp_v = '0;
        exp_d = last_data;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            exp_v = 3'b001 << e.idx;
            exp_d = e.data;
            last_data = e.data;
        end
        check("rd_valid", 32'(rd_valid), 32'(exp_v));
        check("rd_data", 32'(rd_data), 32'(exp_d));
        last_rv = rd_valid;
        last_rd = rd_data;
        for (int i = 0; i < NREQ; i++) if (rd_valid[i]) rv_cnt[i]++;
        rst_n = !rl;
        req = r;
        frame_sync = fs;
        addr = {a_arr[2], a_arr[1], a_arr[0]};
        #1;
        g = gnt;
        if (rl) begin
            check("rst_gnt", 32'(gnt), 32'd0);
            check("rst_rd_valid", 32'(rd_valid), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_rom_en", 32'(rom_en), 32'd0);
            q.delete();
            ptr_m = 0;
            exp_en = 1'b0;
            exp_addr = '0;
            last_data = '0;
            return;
        end
        win = -1;
        for (int k = 0; k < NREQ; k++)
            if (win < 0 && r[(ptr_m + k) % NREQ]) win = (ptr_m + k) % NREQ;
        check("gnt", 32'(gnt), (win < 0) ? 32'd0 : 32'(1 << win));
        for (int i = 0; i < NREQ; i++) if (gnt[i]) gnt_cnt[i]++;
        exp_en = (win >= 0);
        if (win >= 0) begin
            exp_addr = a_arr[win];
            q.push_back('{due: cyc + 3, idx: win, data: rom_fn(a_arr[win])});
        end
        ptr_m = fs ? 0 : ((win >= 0) ? (win + 1) % NREQ : ptr_m);
    endtask

    initial begin
        logic [2:0] g;
        logic [2:0] pend;
        logic       p1_pend;
        logic       fs, rl;
        int         raise_k;

        // Reset, then idle.
        for (int k = 0; k < 3; k++) step(3'b000, 1'b0, 1'b1, g);
        for (int k = 0; k < 20; k++) step(3'b000, 1'b0, 1'b0, g);

        // Single read from P1.
        a_arr[0] = 16'h1234;
        step(3'b001, 1'b0, 1'b0, g);
        check("single_gnt", 32'(g), 32'h1);
        step(3'b000, 1'b0, 1'b0, g);
        check("single_rom_addr", 32'(rom_addr), 32'h1234);
        step(3'b000, 1'b0, 1'b0, g);
        step(3'b000, 1'b0, 1'b0, g);
        check("single_rd_valid", 32'(last_rv), 32'h1);
        check("single_rd_data", 32'(last_rd), 32'hA5);

        // Full contention from ptr = 0.
        step(3'b000, 1'b1, 1'b0, g);
        for (int k = 0; k < 9; k++) begin
            a_arr[k % 3] = 16'($urandom);
            step(3'b111, 1'b0, 1'b0, g);
            check("contend_gnt", 32'(g), 32'(1 << (k % 3)));
        end
        for (int k = 0; k < 4; k++) step(3'b000, 1'b0, 1'b0, g);

        // frame_sync with ptr = 2.
        step(3'b010, 1'b0, 1'b0, g);
        step(3'b111, 1'b1, 1'b0, g);
        check("fsync_gnt0", 32'(g), 32'h4);
        step(3'b111, 1'b0, 1'b0, g);
        check("fsync_gnt1", 32'(g), 32'h1);
        for (int k = 0; k < 4; k++) step(3'b000, 1'b0, 1'b0, g);

        // Reset while a P2 read is in flight.
        a_arr[1] = 16'hBEEF;
        step(3'b010, 1'b0, 1'b0, g);
        check("midrst_gnt", 32'(g), 32'h2);
        step(3'b000, 1'b0, 1'b1, g);
        step(3'b000, 1'b0, 1'b1, g);
        for (int k = 0; k < 5; k++) step(3'b000, 1'b0, 1'b0, g);

        // Sparse P1 against continuous HUD.
        gnt_cnt = '{default: 0};
        rv_cnt  = '{default: 0};
        p1_pend = 1'b0;
        raise_k = 0;
        for (int k = 0; k < 60; k++) begin
            if (!p1_pend && (k % 2 == 1)) begin
                p1_pend = 1'b1;
                raise_k = k;
                a_arr[0] = 16'($urandom);
            end
            step({1'b1, 1'b0, p1_pend}, 1'b0, 1'b0, g);
            if (g[0]) begin
                check("p1_wait_le1", 32'((k - raise_k) <= 1), 32'd1);
                p1_pend = 1'b0;
            end
            if (g[2]) a_arr[2] = 16'($urandom);
        end
        for (int k = 0; k < 4; k++) step(3'b000, 1'b0, 1'b0, g);
        for (int i = 0; i < NREQ; i++) check("rv_vs_gnt_count", 32'(rv_cnt[i]), 32'(gnt_cnt[i]));

        // Randomised traffic with occasional frame_sync, drops and resets.
        pend = '0;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        pend[i] = 1'b1;
                        a_arr[i] = 16'($urandom);
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            fs = ($urandom_range(0, 15) == 0);
            rl = ($urandom_range(0, 99) == 0);
            step(pend, fs, rl, g);
            pend = rl ? 3'b000 : (pend & ~g);
        end
        for (int k = 0; k < 5; k++) step(3'b000, 1'b0, 1'b0, g);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
